pipe_scroller: RTL

- Generalised obstacle engine for the Flappy Bird game.
- Owns NUM_PIPES scrolling pipes: x positions, gap heights, scroll speed, score and run/halt state.
- Sits between game control, collision detection and display; advances one step per single-cycle game tick strobe.
- Adds randomised gap heights, speed levels and scoring on top of the fixed two-pipe scroller.

---
 rtl/flappy_pkg.sv | 10 +
 rtl/pipe_slot.sv | 51 +++++
 rtl/pipe_scroller.sv | 110 +++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// flappy_pkg: shared game state type, default widths and helpers for the Flappy Bird obstacle engine.
package flappy_pkg;
  typedef enum logic [1:0] {IDLE, RUN, HALT} game_state_t;
  localparam int X_W_DEF = 11;
  localparam int SCORE_W_DEF = 10;
  localparam int SCREEN_W = 640;
  function automatic int mid_gap(input int gap_min, input int gap_rw);
    return gap_min + (1 << (gap_rw - 1));
  endfunction
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one scrolling pipe; x/y registers, wrap with fresh gap height, bird-crossing detect.
module pipe_slot
  import flappy_pkg::*;
#(
  parameter int X_W = X_W_DEF,
  parameter int GAP_MIN = 120,
  parameter int GAP_RW = 7,
  parameter int WRAP_DIST = 640
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              init,
  input  logic              step,
  input  logic [2:0]        speed,
  input  logic [GAP_RW-1:0] rnd,
  input  logic [X_W-1:0]    init_x,
  input  logic [X_W-1:0]    init_y,
  input  logic [X_W-1:0]    bird_x,
  output logic [X_W-1:0]    x,
  output logic [X_W-1:0]    y,
  output logic              crossed
);
  localparam int W = X_W + 1;
  logic [X_W-1:0] x_q, x_d, y_q, y_d;
  logic [W-1:0] x_ext, spd_ext;
  logic wrap;
  // Wrapping adds the full ring length so inter-pipe spacing stays exact.
  always_comb begin
    x_ext = {1'b0, x_q};
    spd_ext = W'(speed);
    wrap = x_ext < spd_ext;
    x_d = init ? init_x
        : step ? X_W'(wrap ? x_ext + W'(WRAP_DIST) - spd_ext : x_ext - spd_ext)
        : x_q;
    y_d = init ? init_y
        : (step && wrap) ? X_W'(GAP_MIN) + X_W'(rnd)
        : y_q;
    crossed = step && x_q > bird_x && x_d <= bird_x;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_q <= init_x;
      y_q <= init_y;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end
  assign x = x_q;
  assign y = y_q;
endmodule

// File: rtl/pipe_scroller.sv
// pipe_scroller: game FSM, score/speed keeping and packing around NUM_PIPES pipe slots.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int NUM_PIPES = 2,
  parameter int X_W = X_W_DEF,
  parameter int PIPE_SPACING = 320,
  parameter int INIT_X = 319,
  parameter int GAP_MIN = 120,
  parameter int GAP_RW = 7,
  parameter int SPEED_STEP = 5,
  parameter int MAX_SPEED = 4,
  parameter int SCORE_W = SCORE_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tick,
  input  logic                     start,
  input  logic                     restart,
  input  logic                     collision,
  input  logic [9:0]               random,
  input  logic [X_W-1:0]           bird_x,
  output logic [NUM_PIPES*X_W-1:0] pipe_x,
  output logic [NUM_PIPES*X_W-1:0] pipe_y,
  output logic [SCORE_W-1:0]       score,
  output logic [2:0]               speed,
  output logic                     point,
  output logic                     running
);
  localparam int WRAP_DIST = NUM_PIPES * PIPE_SPACING;
  localparam int Y0 = mid_gap(GAP_MIN, GAP_RW);
  if (NUM_PIPES < 1) begin : g_chk_num
    $error("pipe_scroller: NUM_PIPES must be at least 1");
  end
  if (WRAP_DIST > (1 << X_W) || INIT_X + (NUM_PIPES - 1) * PIPE_SPACING >= (1 << X_W)) begin : g_chk_wrap
    $error("pipe_scroller: pipe coordinates overflow X_W");
  end
  if (MAX_SPEED >= PIPE_SPACING || MAX_SPEED > 7 || MAX_SPEED < 1) begin : g_chk_speed
    $error("pipe_scroller: MAX_SPEED out of range");
  end
  if (GAP_RW < 1 || GAP_RW > 10) begin : g_chk_rw
    $error("pipe_scroller: GAP_RW out of range");
  end
  game_state_t state_q, state_d;
  logic step, inc, bump;
  logic [NUM_PIPES-1:0] crossed;
  logic [SCORE_W-1:0] score_q, score_d, score_inc;
  logic [2:0] speed_q, speed_d;
  logic point_q, point_d;
  logic unused_rnd;
  assign unused_rnd = ^random;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = restart ? IDLE
            : (state_q == IDLE && start) ? RUN
            : (state_q == RUN && collision) ? HALT
            : state_q;
  end
  // Collision and restart both suppress the step of a coincident tick.
  always_comb begin
    running = state_q == RUN;
    step = running && tick && !collision && !restart;
  end
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    pipe_slot #(
      .X_W(X_W),
      .GAP_MIN(GAP_MIN),
      .GAP_RW(GAP_RW),
      .WRAP_DIST(WRAP_DIST)
    ) u_slot (
      .clk(clk),
      .reset_n(reset_n),
      .init(restart),
      .step(step),
      .speed(speed_q),
      .rnd(random[GAP_RW-1:0]),
      .init_x(X_W'(INIT_X + i * PIPE_SPACING)),
      .init_y(X_W'(Y0)),
      .bird_x(bird_x),
      .x(pipe_x[i*X_W +: X_W]),
      .y(pipe_y[i*X_W +: X_W]),
      .crossed(crossed[i])
    );
  end
  always_comb begin
    inc = (|crossed) && !(&score_q);
    score_inc = score_q + SCORE_W'(1);
    bump = inc && (score_inc % SCORE_W'(SPEED_STEP)) == '0 && speed_q < 3'(MAX_SPEED);
    score_d = restart ? '0 : inc ? score_inc : score_q;
    speed_d = restart ? 3'd1 : bump ? speed_q + 3'd1 : speed_q;
    point_d = inc;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score_q <= '0;
      speed_q <= 3'd1;
      point_q <= 1'b0;
    end else begin
      score_q <= score_d;
      speed_q <= speed_d;
      point_q <= point_d;
    end
  end
  assign score = score_q;
  assign speed = speed_q;
  assign point = point_q;
endmodule
